// File: rtl/fp_comp_pkg.sv
// Shared types for the FloPoCo comparator: exception codes, canonical NaN, result flags.
package fp_comp_pkg;

    typedef enum logic [1:0] {
        ZERO   = 2'b00,
        NORMAL = 2'b01,
        INF    = 2'b10,
        NAN    = 2'b11
    } exc_e;

    // Widest legal operand (WE=15, WF=52); narrower builds take the top W bits.
    localparam int unsigned FP_MAX_W = 70;
    localparam logic [FP_MAX_W-1:0] CANON_NAN_MAX = {2'b11, {(FP_MAX_W-2){1'b0}}};

    typedef struct packed {
        logic unordered;
        logic lt;
        logic eq;
        logic gt;
    } cmp_flags_t;

endpackage

// File: rtl/fp_comp_core.sv
// Combinational decode and compare of two FloPoCo operands into one-hot result flags.
module fp_comp_core
    import fp_comp_pkg::*;
#(
    parameter int WE = 8,
    parameter int WF = 23
) (
    input  logic [WE+WF+2:0] x_i,
    input  logic [WE+WF+2:0] y_i,
    output cmp_flags_t       flags_o
);

    exc_e              x_exc, y_exc;
    logic              x_sgn, y_sgn;
    logic [WE+WF-1:0]  x_mag, y_mag;
    logic [2:0]        x_rank, y_rank;

    // Coarse class: -inf < -normal < zero < +normal < +inf; zero ignores sign.
    function automatic logic [2:0] rank(input exc_e e, input logic s);
        case (e)
            NORMAL:  rank = s ? 3'd1 : 3'd3;
            INF:     rank = s ? 3'd0 : 3'd4;
            default: rank = 3'd2;
        endcase
    endfunction

    assign x_exc  = exc_e'(x_i[WE+WF+2 -: 2]);
    assign y_exc  = exc_e'(y_i[WE+WF+2 -: 2]);
    assign x_sgn  = x_i[WE+WF];
    assign y_sgn  = y_i[WE+WF];
    assign x_mag  = x_i[WE+WF-1:0];
    assign y_mag  = y_i[WE+WF-1:0];
    assign x_rank = rank(x_exc, x_sgn);
    assign y_rank = rank(y_exc, y_sgn);

    always_comb begin
        flags_o = '0;
        if (x_exc == NAN || y_exc == NAN) begin
            flags_o.unordered = 1'b1;
        end else if (x_rank != y_rank) begin
            flags_o.lt = (x_rank < y_rank);
            flags_o.gt = (x_rank > y_rank);
        end else if (x_exc == NORMAL) begin
            // Same-sign normals: magnitude order, flipped for negatives.
            if (x_mag == y_mag)
                flags_o.eq = 1'b1;
            else if ((x_mag < y_mag) ^ x_sgn)
                flags_o.lt = 1'b1;
            else
                flags_o.gt = 1'b1;
        end else begin
            flags_o.eq = 1'b1;
        end
    end

endmodule

// File: rtl/fp_comp_pipe.sv
// Pipelined FloPoCo comparator with saturating unordered-result counter.
// Optional min/max outputs are built when FPCOMP_MINMAX_EN is defined.
module fp_comp_pipe
    import fp_comp_pkg::*;
#(
    parameter int WE         = 8,
    parameter int WF         = 23,
    parameter int NUM_STAGES = 1,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic                 in_valid,
    input  logic [WE+WF+2:0]     X,
    input  logic [WE+WF+2:0]     Y,
    output logic                 out_valid,
    output logic                 unordered,
    output logic                 XltY,
    output logic                 XeqY,
    output logic                 XleY,
    output logic                 XgtY,
`ifdef FPCOMP_MINMAX_EN
    output logic [WE+WF+2:0]     min_out,
    output logic [WE+WF+2:0]     max_out,
`endif
    output logic [CNT_W-1:0]     unord_cnt
);

    localparam int W = WE + WF + 3;

    cmp_flags_t                   flags_d;
    cmp_flags_t [NUM_STAGES-1:0]  flags_q;
    logic       [NUM_STAGES-1:0]  vld_q;
    logic       [CNT_W-1:0]       cnt_q;

    fp_comp_core #(.WE(WE), .WF(WF)) u_core (
        .x_i     (X),
        .y_i     (Y),
        .flags_o (flags_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q   <= '0;
            flags_q <= '0;
            cnt_q   <= '0;
        end else if (ce) begin
            vld_q[0]   <= in_valid;
            flags_q[0] <= flags_d;
            for (int i = 1; i < NUM_STAGES; i++) begin
                vld_q[i]   <= vld_q[i-1];
                flags_q[i] <= flags_q[i-1];
            end
            // Counts results as they are consumed from the output register.
            if (vld_q[NUM_STAGES-1] && flags_q[NUM_STAGES-1].unordered && cnt_q != '1)
                cnt_q <= cnt_q + 1'b1;
        end
    end

    assign out_valid = vld_q[NUM_STAGES-1];
    assign unordered = flags_q[NUM_STAGES-1].unordered;
    assign XltY      = flags_q[NUM_STAGES-1].lt;
    assign XeqY      = flags_q[NUM_STAGES-1].eq;
    assign XleY      = flags_q[NUM_STAGES-1].lt | flags_q[NUM_STAGES-1].eq;
    assign XgtY      = flags_q[NUM_STAGES-1].gt;
    assign unord_cnt = cnt_q;

`ifdef FPCOMP_MINMAX_EN
    localparam logic [W-1:0] CANON_NAN = CANON_NAN_MAX[FP_MAX_W-1 -: W];

    logic [W-1:0]                  min_d, max_d;
    logic [NUM_STAGES-1:0][W-1:0]  min_q, max_q;
    logic                          zero_pair;

    // Signed-zero pairs pick by sign so -0 is reported as the minimum.
    assign zero_pair = (exc_e'(X[W-1 -: 2]) == ZERO) && (exc_e'(Y[W-1 -: 2]) == ZERO) &&
                       (X[WE+WF] != Y[WE+WF]);

    always_comb begin
        min_d = (flags_d.lt | flags_d.eq) ? X : Y;
        max_d = (flags_d.lt | flags_d.eq) ? Y : X;
        if (flags_d.unordered) begin
            min_d = CANON_NAN;
            max_d = CANON_NAN;
        end else if (zero_pair) begin
            min_d = X[WE+WF] ? X : Y;
            max_d = X[WE+WF] ? Y : X;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_q <= '0;
            max_q <= '0;
        end else if (ce) begin
            min_q[0] <= min_d;
            max_q[0] <= max_d;
            for (int i = 1; i < NUM_STAGES; i++) begin
                min_q[i] <= min_q[i-1];
                max_q[i] <= max_q[i-1];
            end
        end
    end

    assign min_out = min_q[NUM_STAGES-1];
    assign max_out = max_q[NUM_STAGES-1];
`else
    // Flags-only build: no operand storage in the pipeline.
`endif

endmodule

// File: tb/tb_fp_comp_pipe.sv
// Randomized bench for fp_comp_pipe against a real-valued reference model.
module tb_fp_comp_pipe;

    localparam int WE = 8;
    localparam int WF = 23;
    localparam int NS = 3;
    localparam int W  = WE + WF + 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ce = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] X = '0, Y = '0;

    logic         out_valid, unordered, XltY, XeqY, XleY, XgtY;
    logic [15:0]  unord_cnt;
    logic         out_valid2, unordered2, XltY2, XeqY2, XleY2, XgtY2;
    logic [1:0]   unord_cnt2;
`ifdef FPCOMP_MINMAX_EN
    logic [W-1:0] min_out, max_out, min_out2, max_out2;
`endif

    fp_comp_pipe #(.WE(WE), .WF(WF), .NUM_STAGES(NS), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .X(X), .Y(Y),
        .out_valid(out_valid), .unordered(unordered), .XltY(XltY), .XeqY(XeqY),
        .XleY(XleY), .XgtY(XgtY),
`ifdef FPCOMP_MINMAX_EN
        .min_out(min_out), .max_out(max_out),
`endif
        .unord_cnt(unord_cnt)
    );

    fp_comp_pipe #(.WE(WE), .WF(WF), .NUM_STAGES(NS), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .X(X), .Y(Y),
        .out_valid(out_valid2), .unordered(unordered2), .XltY(XltY2), .XeqY(XeqY2),
        .XleY(XleY2), .XgtY(XgtY2),
`ifdef FPCOMP_MINMAX_EN
        .min_out(min_out2), .max_out(max_out2),
`endif
        .unord_cnt(unord_cnt2)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit expired");
        $fatal(1);
    end

    typedef struct {
        logic         vld, un, lt, eq, gt;
        logic [W-1:0] mn, mx;
    } rec_t;

    int   total = 0;
    int   bad = 0;
    int   nce = 0;
    int   cnt_m = 0;
    int   cnt2_m = 0;
    rec_t ring [16];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] op(input logic [1:0] e, input logic s,
                                        input logic [WE-1:0] ex, input logic [WF-1:0] fr);
        return {e, s, ex, fr};
    endfunction

    // Real value of an ordered operand; infinities sit beyond every normal.
    function automatic real val(input logic [W-1:0] v);
        real m;
        case (v[W-1 -: 2])
            2'b00:   return 0.0;
            2'b10:   return v[WE+WF] ? -1.0e300 : 1.0e300;
            default: begin
                m = (1.0 + real'(v[WF-1:0]) / real'(1 << WF)) *
                    $pow(2.0, real'(v[WE+WF-1:WF]) - 127.0);
                return v[WE+WF] ? -m : m;
            end
        endcase
    endfunction

    function automatic rec_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        rec_t r;
        real  va, vb;
        r.vld = 1'b1;
        r.un = 1'b0; r.lt = 1'b0; r.eq = 1'b0; r.gt = 1'b0;
        if (a[W-1 -: 2] == 2'b11 || b[W-1 -: 2] == 2'b11) begin
            r.un = 1'b1;
            r.mn = {2'b11, {(W-2){1'b0}}};
            r.mx = r.mn;
            return r;
        end
        va = val(a);
        vb = val(b);
        r.lt = va < vb;
        r.eq = va == vb;
        r.gt = va > vb;
        r.mn = (va <= vb) ? a : b;
        r.mx = (va <= vb) ? b : a;
        if (a[W-1 -: 2] == 2'b00 && b[W-1 -: 2] == 2'b00 && a[WE+WF] != b[WE+WF]) begin
            r.mn = a[WE+WF] ? a : b;
            r.mx = a[WE+WF] ? b : a;
        end
        return r;
    endfunction

    function automatic rec_t cur_out();
        rec_t r;
        r.vld = 1'b0; r.un = 1'b0; r.lt = 1'b0; r.eq = 1'b0; r.gt = 1'b0;
        r.mn = '0; r.mx = '0;
        if (nce >= NS) r = ring[(nce - NS) % 16];
        return r;
    endfunction

    task automatic check_outputs();
        rec_t e;
        e = cur_out();
        chk("out_valid", out_valid, e.vld);
        chk("out_valid2", out_valid2, e.vld);
        if (e.vld) begin
            chk("unordered", unordered, e.un);
            chk("XltY", XltY, e.lt);
            chk("XeqY", XeqY, e.eq);
            chk("XleY", XleY, e.lt | e.eq);
            chk("XgtY", XgtY, e.gt);
`ifdef FPCOMP_MINMAX_EN
            chk("min_out", min_out, e.mn);
            chk("max_out", max_out, e.mx);
`endif
        end
        chk("unord_cnt", unord_cnt, cnt_m);
        chk("unord_cnt2", unord_cnt2, cnt2_m);
    endtask

    // Check current outputs, then drive the next cycle and advance the model.
    task automatic step(input logic c, input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
        rec_t e, n;
        @(negedge clk);
        check_outputs();
        ce = c; in_valid = v; X = a; Y = b;
        if (c) begin
            e = cur_out();
            if (e.vld && e.un) begin
                if (cnt_m < 65535) cnt_m++;
                if (cnt2_m < 3) cnt2_m++;
            end
            n = model(a, b);
            n.vld = v;
            ring[nce % 16] = n;
            nce++;
        end
    endtask

    task automatic flush(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, '0);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        check_outputs();
        ce = 1'b0; in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_flags", {unordered, XltY, XeqY, XleY, XgtY}, 0);
        chk("rst_cnt", unord_cnt, 0);
`ifdef FPCOMP_MINMAX_EN
        chk("rst_minmax", {min_out, max_out}, 0);
`endif
        ce = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_hold_valid", out_valid | out_valid2, 0);
        ce = 1'b0;
        #2 rst = 1'b0;
        nce = 0; cnt_m = 0; cnt2_m = 0;
    endtask

    function automatic logic [W-1:0] rand_op();
        logic [1:0]    e;
        logic [WF-1:0] f;
        case ($urandom_range(0, 9))
            0:       e = 2'b00;
            1:       e = 2'b10;
            2:       e = 2'b11;
            default: e = 2'b01;
        endcase
        case ($urandom_range(0, 2))
            0:       f = '0;
            1:       f = 23'h400000;
            default: f = WF'($urandom);
        endcase
        return op(e, 1'($urandom), WE'($urandom_range(125, 130)), f);
    endfunction

    initial begin
        logic [W-1:0] a, b;
        reset_dut();

        step(1, 1, op(2'b01, 0, 8'h7F, 0), op(2'b01, 0, 8'h80, 0));
        step(1, 1, op(2'b00, 0, 8'h12, 5), op(2'b00, 1, 8'h00, 0));
        flush(4);

        reset_dut();
        repeat (5) step(1, 1, op(2'b11, 0, 8'h3, 7), op(2'b10, 1, 0, 0));
        flush(6);
        chk("cnt_after_5_nan", unord_cnt, 5);
        chk("cnt2_saturated", unord_cnt2, 3);

        step(1, 1, op(2'b01, 1, 8'h7F, 23'h400000), op(2'b01, 1, 8'h7F, 0));
        step(1, 0, '0, '0);
        repeat (4) step(0, 0, rand_op(), rand_op());
        flush(2);
        repeat (4) step(0, 1, rand_op(), rand_op());
        flush(3);

        step(1, 1, op(2'b01, 0, 8'h80, 1), op(2'b10, 0, 0, 0));
        step(1, 1, op(2'b10, 1, 0, 0), op(2'b01, 1, 8'hFE, 23'h7FFFFF));
        reset_dut();
        flush(6);

        for (int i = 0; i < 500; i++) begin
            a = rand_op();
            b = ($urandom_range(0, 4) == 0) ? a : rand_op();
            if ($urandom_range(0, 3) == 0) b[WE+WF] = ~b[WE+WF];
            step(1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 9) < 7), a, b);
            if (i == 250) reset_dut();
        end
        flush(5);
        @(negedge clk);
        check_outputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp_comp_pipe.md
FP_COMP_PIPE -- requirements
Module: fp_comp_pipe

Interface
REQ-001 Parameter WE, default 8: exponent width of the FloPoCo-format operands, legal range 3..15.
REQ-002 Parameter WF, default 23: fraction width, legal range 2..52.
REQ-003 Parameter NUM_STAGES, default 1: pipeline depth in enabled cycles, legal range 1..8.
REQ-004 Parameter CNT_W, default 16: width of the unordered-event counter.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 ce  input  1  clock enable; when low, all pipeline state holds.
REQ-008 in_valid  input  1  X/Y carry a comparison request this cycle.
REQ-009 X, Y  input  WE+WF+3 each  FloPoCo operands {exc[1:0], sign, exp[WE-1:0], frac[WF-1:0]}.
REQ-010 out_valid  output  1  result outputs are valid this cycle.
REQ-011 unordered, XltY, XeqY, XleY, XgtY  output  1 each  comparison flags.
REQ-012 min_out, max_out  output  WE+WF+3 each  selected operands; present only with FPCOMP_MINMAX_EN.
REQ-013 unord_cnt  output  CNT_W  saturating count of valid results with unordered=1.

Function
REQ-014 Exception decode: 00 zero, 01 normal, 10 infinity, 11 NaN; exp/frac are ignored for codes other than 01.
REQ-015 If either operand is NaN, the block SHALL set unordered=1 and XltY, XeqY, XleY and XgtY to 0.
REQ-016 Zeros SHALL compare equal regardless of sign (+0 == -0).
REQ-017 Ordering SHALL be -inf < negative normals < zero < positive normals < +inf.
REQ-018 Normals of equal sign SHALL be ordered by the unsigned magnitude {exp,frac}, with the order reversed when sign=1.
REQ-019 Flag relations: XleY = XltY|XeqY; XgtY = !XleY & !unordered; exactly one of lt/eq/gt/unordered is 1.
REQ-020 Latency: a request accepted with in_valid=1 and ce=1 SHALL appear with out_valid=1 exactly NUM_STAGES ce-high cycles later.
REQ-021 Cycles with ce=0 SHALL not advance the pipeline, and outputs SHALL hold their values.
REQ-022 in_valid=0 with ce=1 SHALL inject a bubble; flag and data registers may still load, but out_valid SHALL be 0 for that slot.
REQ-023 unord_cnt SHALL increment by 1 on each cycle with out_valid=1, ce=1 and unordered=1.
REQ-024 unord_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-025 Back-to-back requests, one per ce-high cycle, SHALL be sustained with no gaps (throughput 1).

Reset
REQ-026 While rst=1, all valid bits, flags, unord_cnt, min_out and max_out SHALL be 0, independent of clk and ce.
REQ-027 Requests in flight at reset assertion SHALL be discarded, so that no out_valid pulse is produced for them after release.
REQ-028 The first request accepted after rst deasserts SHALL behave as in REQ-020.

Configuration
REQ-029 Macro FPCOMP_MINMAX_EN: when defined, min_out and max_out are present and pipelined alongside the flags with the same latency.
REQ-030 Min/max selection with FPCOMP_MINMAX_EN:
- min_out = X if XleY, else Y; max_out = Y if XleY, else X.
- For +0/-0 pairs, min_out is the operand with sign 1 and max_out the operand with sign 0.
- If unordered, both outputs are canonical NaN: exc=11, all other bits 0.
REQ-031 When FPCOMP_MINMAX_EN is undefined, the ports and their registers SHALL be absent; flag behaviour SHALL be identical in both builds.

Structure
REQ-032 Package fp_comp_pkg SHALL hold:
- the exception-code enum (ZERO, NORMAL, INF, NAN);
- the canonical-NaN constant pattern;
- a packed result-flags struct {unordered, lt, eq, gt}.
REQ-033 Combinational decode/compare SHALL live in sub-module fp_comp_core (parameters WE, WF) feeding stage 0.
REQ-034 fp_comp_pipe SHALL own the valid shift register, the result pipeline, the min/max muxing and the counter.

Verification (WE=8, WF=23, NUM_STAGES=3 unless stated)
REQ-035 X=1.0 {01,0,0x7F,0}, Y=2.0 {01,0,0x80,0}, in_valid=1 -> 3 cycles later out_valid=1, XltY=1, XleY=1, XeqY=0, XgtY=0, unordered=0, min_out=X.
REQ-036 X=+0 {00,0,..}, Y=-0 {00,1,..} -> XeqY=1, XleY=1, XltY=0; with macro: min_out=Y, max_out=X.
REQ-037 X=NaN {11,...}, Y=-inf {10,1,..} on 5 consecutive cycles -> unordered=1 on 5 consecutive out_valid cycles, unord_cnt=5; with macro: min_out=max_out=canonical NaN.
REQ-038 X=-1.5 {01,1,0x7F,0x400000}, Y=-1.0 {01,1,0x7F,0} -> XltY=1; then issue a request and hold ce=0 for 4 cycles mid-flight -> out_valid is delayed by exactly 4 cycles and flags are unchanged.
REQ-039 Assert rst asynchronously while 2 requests are in flight -> all outputs are 0 immediately and no out_valid follows after release.
REQ-040 CNT_W=2: 5 unordered results -> unord_cnt reads 1, 2, 3, 3, 3.
